// File: rtl/risc16_issue_stage_if.sv
// RiSC-16 issue stage: shared decode constants, id/ex bundle and handshake interface.
// Master drives instructions in and consumes ALU operands; slave is the stage.
package risc16_pkg;
  localparam int XLEN = 16;
  localparam int ALU_FUNCT_LEN = 2;

  localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = 2'd0;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = 2'd1;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASSA = 2'd2;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_SUB   = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]          src1;
    logic [XLEN-1:0]          src2;
    logic [ALU_FUNCT_LEN-1:0] funct;
    logic [2:0]               wb_dest;
    logic                     wb_en;
    logic                     mem_re;
    logic                     mem_we;
    logic [XLEN-1:0]          store_data;
    logic                     is_beq;
    logic [XLEN-1:0]          br_target;
    logic                     is_jalr;
    logic [XLEN-1:0]          jmp_target;
  } id_ex_t;
endpackage

interface risc16_issue_if
  import risc16_pkg::*;
#(
  parameter int WORD_LENGTH = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WORD_LENGTH-1:0]   in_instr;
  logic [WORD_LENGTH-1:0]   in_pc;
  logic [WORD_LENGTH-1:0]   in_ra_val;
  logic [WORD_LENGTH-1:0]   in_rb_val;
  logic [WORD_LENGTH-1:0]   in_rc_val;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_LENGTH-1:0]   alu_src1;
  logic [WORD_LENGTH-1:0]   alu_src2;
  logic [ALU_FUNCT_LEN-1:0] alu_funct;
  logic [2:0]               wb_dest;
  logic                     wb_en;
  logic                     mem_re;
  logic                     mem_we;
  logic [WORD_LENGTH-1:0]   store_data;
  logic                     is_beq;
  logic [WORD_LENGTH-1:0]   br_target;
  logic                     is_jalr;
  logic [WORD_LENGTH-1:0]   jmp_target;

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  in_ra_val, in_rb_val, in_rc_val,
    input  out_ready,
    output in_ready, out_valid,
    output alu_src1, alu_src2, alu_funct,
    output wb_dest, wb_en, mem_re, mem_we,
    output store_data, is_beq, br_target,
    output is_jalr, jmp_target
  );

  modport master (
    output in_valid, in_instr, in_pc,
    output in_ra_val, in_rb_val, in_rc_val,
    output out_ready,
    input  in_ready, out_valid,
    input  alu_src1, alu_src2, alu_funct,
    input  wb_dest, wb_en, mem_re, mem_we,
    input  store_data, is_beq, br_target,
    input  is_jalr, jmp_target
  );
endinterface

// File: rtl/risc16_issue_stage.sv
// RiSC-16 decode-to-execute boundary: operand/funct decode
// into a 2-entry skid buffer with registered in_ready.
module risc16_issue_stage
  import risc16_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  risc16_issue_if.slave   bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  id_ex_t     head_q, head_d;
  id_ex_t     skid_q, skid_d;
  id_ex_t     dec;

  logic                   push, pop, out_valid, wr;
  logic [2:0]             op, ra;
  logic [WORD_LENGTH-1:0] sext, pc1;

  assign op   = bus.in_instr[15:13];
  assign ra   = bus.in_instr[12:10];
  assign sext = {{(WORD_LENGTH-7){bus.in_instr[6]}},
                 bus.in_instr[6:0]};
  assign pc1  = bus.in_pc + 1'b1;

  always_comb begin
    dec            = '0;
    wr             = 1'b0;
    dec.funct      = ALU_ADD;
    dec.wb_dest    = ra;
    dec.store_data = bus.in_ra_val;
    dec.br_target  = pc1 + sext;
    dec.jmp_target = bus.in_rb_val;
    unique case (1'b1)
      op == OP_ADD: begin
        dec.src1 = bus.in_rb_val;
        dec.src2 = bus.in_rc_val;
        wr       = 1'b1;
      end
      op == OP_ADDI: begin
        dec.src1 = bus.in_rb_val;
        dec.src2 = sext;
        wr       = 1'b1;
      end
      op == OP_NAND: begin
        dec.src1  = bus.in_rb_val;
        dec.src2  = bus.in_rc_val;
        dec.funct = ALU_NAND;
        wr        = 1'b1;
      end
      op == OP_LUI: begin
        dec.src1  = {bus.in_instr[9:0], 6'b0};
        dec.funct = ALU_PASSA;
        wr        = 1'b1;
      end
      op == OP_SW: begin
        dec.src1   = bus.in_rb_val;
        dec.src2   = sext;
        dec.mem_we = 1'b1;
      end
      op == OP_LW: begin
        dec.src1   = bus.in_rb_val;
        dec.src2   = sext;
        dec.mem_re = 1'b1;
        wr         = 1'b1;
      end
      op == OP_BEQ: begin
        dec.src1   = bus.in_ra_val;
        dec.src2   = bus.in_rb_val;
        dec.funct  = ALU_SUB;
        dec.is_beq = 1'b1;
      end
      op == OP_JALR: begin
        dec.src1    = pc1;
        dec.funct   = ALU_PASSA;
        dec.is_jalr = 1'b1;
        wr          = 1'b1;
      end
      default: ;
    endcase
    // r0 is hardwired zero, so never request a write to it
    dec.wb_en = wr & (ra != 3'd0);
  end

  assign out_valid = (count_q != EMPTY);
  assign push = bus.in_valid & in_ready_q & ~flush;
  assign pop  = out_valid & bus.out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = EMPTY;
    end else begin
      case (count_q)
        EMPTY: begin
          if (push) begin
            head_d  = dec;
            count_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            skid_d  = dec;
            count_d = FULL;
          end else if (pop) begin
            count_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = ONE;
          end
        end
        default: count_d = EMPTY;
      endcase
    end
    in_ready_d = (count_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.alu_src1   = head_q.src1;
  assign bus.alu_src2   = head_q.src2;
  assign bus.alu_funct  = head_q.funct;
  assign bus.wb_dest    = head_q.wb_dest;
  assign bus.store_data = head_q.store_data;
  assign bus.br_target  = head_q.br_target;
  assign bus.jmp_target = head_q.jmp_target;
  assign bus.wb_en      = head_q.wb_en & out_valid;
  assign bus.mem_re     = head_q.mem_re & out_valid;
  assign bus.mem_we     = head_q.mem_we & out_valid;
  assign bus.is_beq     = head_q.is_beq & out_valid;
  assign bus.is_jalr    = head_q.is_jalr & out_valid;

endmodule

// File: tb/tb_risc16_issue_stage.sv
// Bench for risc16_issue_stage: directed cases plus random
// traffic against a queue-based reference model.
module tb_risc16_issue_stage;
  import risc16_pkg::*;

  typedef logic [89:0] pay_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;

  risc16_issue_if #(.WORD_LENGTH(16)) bus ();

  risc16_issue_stage #(.WORD_LENGTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  pay_t q[$];
  logic rdy_m = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pay_t model(input logic [15:0] i, pc,
                                 ra, rb, rc);
    logic [15:0] s, s1, s2;
    logic [1:0]  f;
    logic        w, mr, mw, bq, jr;
    s  = {{9{i[6]}}, i[6:0]};
    s1 = 0; s2 = 0; f = ALU_ADD;
    w = 0; mr = 0; mw = 0; bq = 0; jr = 0;
    case (int'(i[15:13]))
      0: begin s1 = rb; s2 = rc; w = 1; end
      1: begin s1 = rb; s2 = s; w = 1; end
      2: begin s1 = rb; s2 = rc; f = ALU_NAND; w = 1; end
      3: begin s1 = i[9:0] * 16'd64; f = ALU_PASSA; w = 1; end
      4: begin s1 = rb; s2 = s; mw = 1; end
      5: begin s1 = rb; s2 = s; mr = 1; w = 1; end
      6: begin s1 = ra; s2 = rb; f = ALU_SUB; bq = 1; end
      default: begin
        s1 = pc + 16'd1; f = ALU_PASSA; jr = 1; w = 1;
      end
    endcase
    if (i[12:10] == 3'd0) w = 0;
    return {s1, s2, f, i[12:10], w, mr, mw, ra,
            bq, 16'(pc + 16'd1 + s), jr, rb};
  endfunction

  function automatic pay_t dutvec();
    return {bus.alu_src1, bus.alu_src2, bus.alu_funct,
            bus.wb_dest, bus.wb_en, bus.mem_re, bus.mem_we,
            bus.store_data, bus.is_beq, bus.br_target,
            bus.is_jalr, bus.jmp_target};
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready", bus.in_ready, rdy_m);
    if (q.size() != 0)
      chk("payload", dutvec(), q[0]);
    else
      chk("ctl_idle", {bus.wb_en, bus.mem_re, bus.mem_we,
                       bus.is_beq, bus.is_jalr}, 0);
  endtask

  task automatic step(input logic v, input logic [15:0] ins, pc,
                      ra, rb, rc, input logic ordy, fl);
    logic r;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.in_ra_val = ra;
    bus.in_rb_val = rb;
    bus.in_rc_val = rc;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    if (rst_n) begin
      if (fl) begin
        q.delete();
      end else begin
        r = rdy_m;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (v && r) q.push_back(model(ins, pc, ra, rb, rc));
      end
      rdy_m = (q.size() < 2);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, ordy, 1'b0);
  endtask

  function automatic logic [15:0] rrr(input logic [2:0] o, a, b, c);
    return {o, a, b, 4'b0, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] o, a, b,
                                      input logic [6:0] im);
    return {o, a, b, im};
  endfunction

  initial begin
    int nv;
    logic [15:0] ia, ib, ic;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
    bus.in_ra_val = 0; bus.in_rb_val = 0; bus.in_rc_val = 0;
    bus.out_ready = 0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_payload", dutvec(),
        {32'h0, ALU_ADD, 56'h0});
    rst_n = 1'b1;
    idle(1'b1);
    chk("rst_release_rdy", bus.in_ready, 1);

    step(1, rrr(OP_ADD, 3'd1, 3'd2, 3'd3), 16'h10, 0, 5, 7, 1, 0);
    chk("add_src", {bus.alu_src1, bus.alu_src2}, {16'd5, 16'd7});
    chk("add_ctl", {bus.alu_funct, bus.wb_dest, bus.wb_en},
        {ALU_ADD, 3'd1, 1'b1});
    step(1, rri(OP_ADDI, 3'd4, 3'd4, 7'h7F), 16'h11, 0, 0, 0, 1, 0);
    chk("addi_src2", bus.alu_src2, 16'hFFFF);
    step(1, {OP_LUI, 3'd5, 10'h3FF}, 16'h12, 0, 0, 0, 1, 0);
    chk("lui_src1", {bus.alu_src1, bus.alu_funct},
        {16'hFFC0, ALU_PASSA});
    step(1, rri(OP_BEQ, 3'd1, 3'd2, 7'd1), 16'hFFFF, 3, 3, 0, 1, 0);
    chk("beq_wrap", {bus.is_beq, bus.alu_funct, bus.br_target},
        {1'b1, ALU_SUB, 16'h0001});
    step(1, rrr(OP_ADD, 3'd0, 3'd2, 3'd3), 16'h13, 0, 1, 2, 1, 0);
    chk("r0_wb_en", bus.wb_en, 0);
    idle(1'b1);

    ia = rrr(OP_ADD, 3'd1, 3'd1, 3'd1);
    ib = rrr(OP_NAND, 3'd2, 3'd2, 3'd2);
    ic = rri(OP_LW, 3'd3, 3'd3, 7'd3);
    step(1, ia, 16'h20, 1, 2, 3, 0, 0);
    step(1, ib, 16'h21, 4, 5, 6, 0, 0);
    chk("bp_full_rdy", bus.in_ready, 0);
    repeat (3) step(1, ic, 16'h22, 7, 8, 9, 0, 0);
    repeat (3) step(1, ic, 16'h22, 7, 8, 9, 1, 0);
    idle(1'b1);

    nv = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, rri(OP_ADDI, 3'(k), 3'd1, 7'(k)), 16'(k), 0, 16'(k),
           0, 1, 0);
      if (bus.out_valid) nv++;
    end
    chk("throughput", nv, 8);
    idle(1'b1);

    step(1, ia, 16'h30, 1, 1, 1, 0, 0);
    step(1, ib, 16'h31, 2, 2, 2, 0, 0);
    step(1, ic, 16'h32, 3, 3, 3, 0, 1);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_rdy", bus.in_ready, 1);
    repeat (3) idle(1'b1);

    step(1, ia, 16'h40, 1, 1, 1, 0, 0);
    step(1, ib, 16'h41, 1, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", bus.out_valid, 0);
    q.delete();
    rdy_m = 1'b0;
    chk("async_rst_rdy", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
    end
    repeat (3) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
